orient_bin: RTL and testbench
=============================

ORIENT_BIN -- requirements
Module: orient_bin

Interface
REQ-001 SHALL have parameter G_W, default 9, giving the signed gradient input width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port gx, input, G_W, signed horizontal gradient.
REQ-005 SHALL have port gy, input, G_W, signed vertical gradient.
REQ-006 SHALL have port in_valid, input, 1, gx/gy valid.
REQ-007 SHALL have port in_ready, output, 1, block can accept a sample.
REQ-008 SHALL have port bin, output, 4, unsigned orientation bin 0..8.
REQ-009 SHALL have port mag, output, G_W+1, unsigned L1 magnitude |gx|+|gy|.
REQ-010 SHALL have port out_valid, output, 1, bin/mag valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.

Function
REQ-012 SHALL classify unsigned orientation (0..180 deg) into 9 bins of 20 deg, bin k = [20k, 20k+20), without a divider, by comparing |gy|*2^16 against gx*T[j].
REQ-013 SHALL use constants T[1..4] = 0x05D2D, 0x0D6CF, 0x1BB68, 0x5ABD9 (tan 20/40/60/80 deg, 16 fractional bits); the fraction width is fixed at 16.
REQ-014 SHALL fold on capture: if gx<0, or gx==0 and gy<0, negate both; folded gx is G_W+1-bit unsigned, so gx=-256 folds to 256 without overflow; sign of folded gy is kept as flag neg.
REQ-015 SHALL compute mag = |gx|+|gy| on capture, without saturation (max 512 for G_W=9).
REQ-016 SHALL implement FSM IDLE, CMP, DONE; in_ready=1 only in IDLE.
REQ-017 IDLE: on in_valid&&in_ready, capture/fold inputs, clear count, set j=1, go CMP.
REQ-018 CMP: one comparison per cycle, j=1..4 in order, fixed 4 cycles (no early exit); if neg=0, count++ when |gy|*2^16 >= gx*T[j]; if neg=1, count++ when |gy|*2^16 > gx*T[j]; after j=4 go DONE.
REQ-019 Entering DONE: bin = count if neg=0, bin = 8-count if neg=1; out_valid=1.
REQ-020 Zero vector (folded gx==0 and gy==0) SHALL give bin=0, mag=0, overriding REQ-019.
REQ-021 Latency: sample accepted at edge N gives out_valid=1 after edge N+5.
REQ-022 DONE: bin, mag, out_valid held stable while out_ready=0; on out_valid&&out_ready go IDLE, out_valid=0, in_ready=1 after that edge.
REQ-023 SHALL NOT accept a new sample in the same cycle as the output handshake; throughput one sample per 6 cycles with out_ready held 1.
REQ-024 in_valid asserted outside IDLE SHALL be ignored (no capture, no state change).
REQ-025 Products SHALL be evaluated at full width (G_W+1+19 bits) with no truncation.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, in_ready=1, out_valid=0, bin=0, mag=0, count=0, j=0, independent of clk.
REQ-027 Reset asserted in CMP or DONE SHALL discard the in-flight sample; no out_valid follows reset release without a new input handshake.
REQ-028 First input handshake SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-029 gx=10, gy=10, out_ready=1 -> bin=2, mag=20, out_valid exactly 5 edges after accept.
REQ-030 gx=-10, gy=10 -> bin=6, mag=20; gx=0, gy=5 -> bin=4; gx=0, gy=-5 -> bin=4, mag=5.
REQ-031 gx=-256, gy=-256 -> bin=2, mag=512; gx=0, gy=0 -> bin=0, mag=0.
REQ-032 Boundary: gx=65536-scaled equivalence not reachable; instead gx=1, gy=0 -> bin=0; gx=1, gy=-1 -> bin=6; gx=1, gy=6 -> bin=4; gx=1, gy=-6 -> bin=4.
REQ-033 Backpressure: out_ready=0 for 10 cycles in DONE -> bin/mag/out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> single handshake, in_ready=1 next cycle.
REQ-034 Reset mid-operation: rst_n=0 asynchronously during CMP j=2 -> out_valid=0, in_ready=1 immediately; after release no output until next accepted sample.

Source files
------------

// File: rtl/orient_bin.sv
// -----------------------------------------------------------------------------
// orient_bin
//   Classifies the unsigned orientation (0..180 deg) of a gradient vector
//   (gx, gy) into one of nine 20-degree bins and reports its L1 magnitude.
//   No divider is used. The vector is folded into the right half-plane, then
//   |gy|*2^16 is compared against gx*tan(20/40/60/80 deg), one threshold per
//   clock. Each comparison result is registered before it is accumulated, so
//   a sample accepted at edge N produces out_valid after edge N+5.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   gx, gy     : signed gradients, G_W bits
//   in_valid   : gx/gy valid
//   in_ready   : high only while idle (a sample can be accepted)
//   bin        : orientation bin 0..8
//   mag        : |gx| + |gy|, G_W+1 bits, not saturated
//   out_valid  : bin/mag valid; held until out_ready
//   out_ready  : consumer accepts the result
// -----------------------------------------------------------------------------
module orient_bin #(
  parameter int G_W = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic signed [G_W-1:0] gx,
  input  logic signed [G_W-1:0] gy,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [3:0]            bin,
  output logic [G_W:0]          mag,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int FW = 16;           // fractional bits of the tangent constants
  localparam int TW = 19;           // width of the largest constant (tan 80)
  localparam int PW = G_W + 1 + TW; // full product width, nothing truncated

  localparam logic [TW-1:0] T1 = 19'h05D2D; // tan 20
  localparam logic [TW-1:0] T2 = 19'h0D6CF; // tan 40
  localparam logic [TW-1:0] T3 = 19'h1BB68; // tan 60
  localparam logic [TW-1:0] T4 = 19'h5ABD9; // tan 80

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_DONE} state_t;

  state_t r_state, w_next;

  // Fold on capture. Inputs are widened by one bit first, so -2^(G_W-1)
  // negates to +2^(G_W-1) without overflow.
  logic signed [G_W:0] w_gx_s, w_gy_s, w_gy_f;
  logic [G_W:0]        w_gx_f, w_agy, w_mag;
  logic                w_fold, w_neg, w_zero;

  assign w_gx_s = {gx[G_W-1], gx};
  assign w_gy_s = {gy[G_W-1], gy};
  assign w_fold = gx[G_W-1] | ((gx == '0) & gy[G_W-1]);
  assign w_gx_f = w_fold ? -w_gx_s : w_gx_s;
  assign w_gy_f = w_fold ? -w_gy_s : w_gy_s;
  assign w_neg  = w_gy_f[G_W];
  assign w_agy  = w_neg ? -w_gy_f : w_gy_f;
  assign w_zero = (gx == '0) && (gy == '0);
  assign w_mag  = w_gx_f + w_agy; // folded gx is |gx|

  // Captured operands and progress.
  logic [G_W:0] r_gx, r_agy, r_mag;
  logic         r_neg, r_zero;
  logic [2:0]   r_count;          // thresholds passed so far, 0..4
  logic [2:0]   r_j;              // 1..4 = threshold under test, 0 = drain cycle
  logic         r_hit, r_hit_vld; // registered comparison awaiting accumulation
  logic [3:0]   r_bin;

  // One threshold per cycle.
  logic [TW-1:0] w_t;
  logic [PW-1:0] w_lhs, w_rhs;
  logic          w_hit;
  logic [2:0]    w_cnt_fin;
  logic [3:0]    w_bin_fin;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_t = '0;
    case (r_j)
      3'd1:    w_t = T1;
      3'd2:    w_t = T2;
      3'd3:    w_t = T3;
      3'd4:    w_t = T4;
      default: w_t = '0;
    endcase
  end

  assign w_lhs = PW'({r_agy, {FW{1'b0}}});
  assign w_rhs = PW'(r_gx) * PW'(w_t);
  // Lower half-plane is mirrored to 180-theta; the strict compare keeps the
  // bin edges half-open ([20k, 20k+20)) after mirroring.
  assign w_hit = r_neg ? (w_lhs > w_rhs) : (w_lhs >= w_rhs);

  // The j=4 result is still in r_hit during the drain cycle.
  assign w_cnt_fin = r_count + {2'b00, r_hit};
  always_comb begin
    w_bin_fin = {1'b0, w_cnt_fin};
    if (r_zero)     w_bin_fin = 4'd0;
    else if (r_neg) w_bin_fin = 4'd8 - {1'b0, w_cnt_fin};
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)   w_next = S_CMP;
      S_CMP:   if (r_j == '0)  w_next = S_DONE;
      S_DONE:  if (out_ready)  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gx      <= '0;
      r_agy     <= '0;
      r_mag     <= '0;
      r_neg     <= 1'b0;
      r_zero    <= 1'b0;
      r_count   <= '0;
      r_j       <= '0;
      r_hit     <= 1'b0;
      r_hit_vld <= 1'b0;
      r_bin     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_gx      <= w_gx_f;
            r_agy     <= w_agy;
            r_neg     <= w_neg;
            r_zero    <= w_zero;
            r_mag     <= w_mag;
            r_count   <= '0;
            r_j       <= 3'd1;
            r_hit     <= 1'b0;
            r_hit_vld <= 1'b0;
          end
        end
        S_CMP: begin
          if (r_hit_vld) r_count <= r_count + {2'b00, r_hit};
          if (r_j != '0) begin
            r_hit     <= w_hit;
            r_hit_vld <= 1'b1;
            r_j       <= (r_j == 3'd4) ? 3'd0 : r_j + 3'd1;
          end else begin
            r_bin     <= w_bin_fin;
            r_hit_vld <= 1'b0;
          end
        end
        default: ; // DONE holds everything stable
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign bin       = r_bin;
  assign mag       = r_mag;

endmodule

// File: tb/tb_orient_bin.sv
// -----------------------------------------------------------------------------
// tb_orient_bin
//   Directed bench for orient_bin: reset state, bin/magnitude for hand-computed
//   vectors (including fold and half-open bin-edge cases), accept-to-valid
//   latency, backpressure hold, and asynchronous reset in the middle of a
//   computation.
// -----------------------------------------------------------------------------
module tb_orient_bin;

  localparam int G_W = 9;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic signed [G_W-1:0] gx = '0;
  logic signed [G_W-1:0] gy = '0;
  logic                  in_valid = 1'b0;
  logic                  out_ready = 1'b1;
  logic                  in_ready;
  logic [3:0]            bin;
  logic [G_W:0]          mag;
  logic                  out_valid;

  int n_vec = 0;
  int n_err = 0;

  orient_bin #(.G_W(G_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gx        (gx),
    .gy        (gy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .mag       (mag),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Applies one sample with out_ready held high; called mid-cycle while idle.
  task automatic run(input int x, input int y, input int exp_bin, input int exp_mag,
                     input string tag);
    int lat;
    gx       = x[G_W-1:0];
    gy       = y[G_W-1:0];
    in_valid = 1'b1;
    check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, "/latency"}, 32'(lat), 32'd5);
    check({tag, "/bin"}, 32'(bin), 32'(exp_bin));
    check({tag, "/mag"}, 32'(mag), 32'(exp_mag));
    if (lat != 0) begin
      @(posedge clk); #1;
      check({tag, "/post_hs_valid"}, 32'(out_valid), 32'd0);
      check({tag, "/post_hs_ready"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    int seen;

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("reset/in_ready", 32'(in_ready), 32'd1);
    check("reset/out_valid", 32'(out_valid), 32'd0);
    check("reset/bin", 32'(bin), 32'd0);
    check("reset/mag", 32'(mag), 32'd0);
    #10 rst_n = 1'b1; // t=12; first edge with rst_n=1 is t=15 and accepts

    run(  10,   10, 2,  20, "v45");
    run( -10,   10, 6,  20, "v135");
    run( -10,  -10, 2,  20, "v225_fold");
    run(   0,    5, 4,   5, "v90");
    run(   0,   -5, 4,   5, "v270_fold");
    run(-256, -256, 2, 512, "vmax");
    run(   0,    0, 0,   0, "vzero");
    run(   1,    0, 0,   1, "v0");
    run(   1,   -1, 6,   2, "v315");
    run(   1,    6, 4,   7, "v80_6");
    run(   1,   -6, 4,   7, "v280_6");
    run( 100,   -1, 8, 101, "v179");

    // Backpressure: result held while out_ready is low, inputs ignored.
    out_ready = 1'b0;
    gx        = 9'sd10;
    gy        = -9'sd10;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("bp/valid", 32'(out_valid), 32'd1);
    check("bp/bin", 32'(bin), 32'd6);
    check("bp/mag", 32'(mag), 32'd20);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      gx       = 9'(i * 13 + 3);
      gy       = 9'(i * 7);
      @(posedge clk); #1;
      check("bp/hold_valid", 32'(out_valid), 32'd1);
      check("bp/hold_bin", 32'(bin), 32'd6);
      check("bp/hold_mag", 32'(mag), 32'd20);
      check("bp/hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp/release_valid", 32'(out_valid), 32'd0);
    check("bp/release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("bp/idle_valid", 32'(out_valid), 32'd0);
    check("bp/idle_ready", 32'(in_ready), 32'd1);

    // Reset while comparing threshold j=2.
    gx       = 9'sd10;
    gy       = 9'sd10;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid/busy", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid/in_ready", 32'(in_ready), 32'd1);
    check("mid/out_valid", 32'(out_valid), 32'd0);
    check("mid/bin", 32'(bin), 32'd0);
    check("mid/mag", 32'(mag), 32'd0);
    #3 rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    check("mid/no_ghost_out", 32'(seen), 32'd0);
    run(1, 6, 4, 7, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
